// File: rtl/piano_tone_pkg.sv
// ============================================================================
// Module      : piano_tone_pkg
// Description : Shared constants and types for the polyphonic tone synth.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package piano_tone_pkg;

    localparam int CNT_W = 19;

    // Half periods in 50 MHz clocks for C4..D6; element k is note k.
    localparam logic [15:0][CNT_W-1:0] HALF_PERIOD = {
        19'd21284, 19'd23889, 19'd25310, 19'd28409,
        19'd31888, 19'd35793, 19'd37922, 19'd42568,
        19'd47778, 19'd50620, 19'd56818, 19'd63775,
        19'd71586, 19'd75842, 19'd85132, 19'd95554
    };

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        OUT  = 1'b1
    } state_e;

endpackage

`default_nettype wire

// File: rtl/tone_osc.sv
// ============================================================================
// Module      : tone_osc
// Description : Square-wave half-period counter with phase flop.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tone_osc
    import piano_tone_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             hold,
    input  logic [CNT_W-1:0] half_period,
    output logic             phase
);

    logic [CNT_W-1:0] cnt_q;
    logic             phase_q;

    // >= rather than == so a shrinking half period wraps immediately.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (hold) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else if (cnt_q >= half_period) begin
            cnt_q   <= '0;
            phase_q <= ~phase_q;
        end else begin
            cnt_q   <= cnt_q + 1'b1;
        end
    end

    assign phase = phase_q;

endmodule

`default_nettype wire

// File: rtl/poly_tone_synth.sv
// ============================================================================
// Module      : poly_tone_synth
// Description : Polyphonic square-wave synth with voicing, envelopes, mixer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module poly_tone_synth
    import piano_tone_pkg::*;
#(
    parameter int NUM_KEYS     = 10,
    parameter int NUM_VOICES   = 4,
    parameter int GAIN_W       = 8,
    parameter int AMP_SHIFT    = 16,
    parameter int ATTACK_STEP  = 8,
    parameter int RELEASE_STEP = 2
) (
    input  logic                              CLOCK_50,
    input  logic                              resetn,
    input  logic [NUM_KEYS-1:0]               keys,
    input  logic [1:0]                        octave_shift,
    input  logic                              sample_ready,
    output logic                              sample_valid,
    output logic signed [31:0]                sample,
    output logic [$clog2(NUM_VOICES+1)-1:0]   active_voices
);

    localparam int KW    = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1;
    localparam int VW    = $clog2(NUM_VOICES + 1);
    localparam int ACC_W = (GAIN_W + AMP_SHIFT + 6 > 36) ? GAIN_W + AMP_SHIFT + 6 : 36;
    localparam logic [GAIN_W-1:0]       GAIN_MAX = '1;
    localparam logic signed [ACC_W-1:0] SAT_HI   = ACC_W'(2147483647);
    localparam logic signed [ACC_W-1:0] SAT_LO   = ~SAT_HI;

    logic [NUM_KEYS-1:0]     sync1_q, pressed_q, elig_q, voiced_q;
    logic [GAIN_W-1:0]       gain_q [NUM_KEYS];
    logic [GAIN_W-1:0]       gain_d [NUM_KEYS];
    state_e                  state_q;
    logic [KW-1:0]           k_q;
    logic signed [ACC_W-1:0] acc_q, acc_d, amp;
    logic [VW-1:0]           vcnt_q, vcnt_d, active_q;
    logic                    valid_q, cur_voiced;
    logic signed [31:0]      sample_q, sample_d;
    logic [NUM_KEYS-1:0]     phase, hold, elig_now, elig_sel;
    logic [1:0]              shift;
    logic [GAIN_W:0]         gain_up;

    assign shift = (octave_shift == 2'd3) ? 2'd2 : octave_shift;

    generate
        for (genvar g = 0; g < NUM_KEYS; g++) begin : g_osc
            assign elig_now[g] = pressed_q[g] | (gain_q[g] != '0);
            assign hold[g]     = ~elig_now[g];
            tone_osc u_osc (
                .clk         (CLOCK_50),
                .resetn      (resetn),
                .hold        (hold[g]),
                .half_period (HALF_PERIOD[g] >> shift),
                .phase       (phase[g])
            );
        end
    endgenerate

    // Key 0 sees the live eligibility; later keys use the snapshot it took.
    always_comb begin
        elig_sel   = (k_q == '0) ? elig_now : elig_q;
        cur_voiced = elig_sel[k_q] && (vcnt_q < VW'(NUM_VOICES));
        amp        = $signed({{(ACC_W-GAIN_W){1'b0}}, gain_q[k_q]}) <<< AMP_SHIFT;
        acc_d      = acc_q;
        vcnt_d     = vcnt_q;
        if (cur_voiced) begin
            acc_d  = phase[k_q] ? acc_q + amp : acc_q - amp;
            vcnt_d = vcnt_q + 1'b1;
        end
        if (acc_d > SAT_HI)      sample_d = 32'sh7FFF_FFFF;
        else if (acc_d < SAT_LO) sample_d = 32'sh8000_0000;
        else                     sample_d = acc_d[31:0];
    end

    always_comb begin
        gain_up = '0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            gain_d[k] = '0;
            if (voiced_q[k]) begin
                if (pressed_q[k]) begin
                    gain_up   = {1'b0, gain_q[k]} + (GAIN_W+1)'(ATTACK_STEP);
                    gain_d[k] = (gain_up > {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_up[GAIN_W-1:0];
                end else begin
                    gain_d[k] = (gain_q[k] > GAIN_W'(RELEASE_STEP)) ?
                                gain_q[k] - GAIN_W'(RELEASE_STEP) : '0;
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            sync1_q   <= '0;
            pressed_q <= '0;
            elig_q    <= '0;
            voiced_q  <= '0;
            state_q   <= SCAN;
            k_q       <= '0;
            acc_q     <= '0;
            vcnt_q    <= '0;
            valid_q   <= 1'b0;
            sample_q  <= '0;
            active_q  <= '0;
            for (int k = 0; k < NUM_KEYS; k++) gain_q[k] <= '0;
        end else begin
            sync1_q   <= keys;
            pressed_q <= sync1_q;
            case (state_q)
                SCAN: begin
                    if (k_q == '0) elig_q <= elig_now;
                    if (cur_voiced) voiced_q[k_q] <= 1'b1;
                    acc_q  <= acc_d;
                    vcnt_q <= vcnt_d;
                    if (k_q == KW'(NUM_KEYS - 1)) begin
                        state_q  <= OUT;
                        sample_q <= sample_d;
                        active_q <= vcnt_d;
                        valid_q  <= 1'b1;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                OUT: begin
                    if (sample_ready) begin
                        for (int k = 0; k < NUM_KEYS; k++) gain_q[k] <= gain_d[k];
                        voiced_q <= '0;
                        state_q  <= SCAN;
                        k_q      <= '0;
                        acc_q    <= '0;
                        vcnt_q   <= '0;
                        valid_q  <= 1'b0;
                    end
                end
                default: state_q <= SCAN;
            endcase
        end
    end

    assign sample_valid  = valid_q;
    assign sample        = sample_q;
    assign active_voices = active_q;

endmodule

`default_nettype wire
